// File: rtl/xgmii_pkg.sv
// Shared XGMII constants and the {ctrl, data} word type used by xgmii_fifo and its RAM.
// No timing or flow control of its own; idle word is the reset/fill value downstream.
package xgmii_pkg;

   localparam int XGMII_DW = 64;
   localparam int XGMII_CW = 8;

   localparam logic [XGMII_DW-1:0] XGMII_IDLE_DATA = 64'h0707070707070707;
   localparam logic [XGMII_CW-1:0] XGMII_IDLE_CTRL = 8'hFF;

   typedef struct packed {
      logic [XGMII_CW-1:0] ctrl;
      logic [XGMII_DW-1:0] data;
   } xgmii_word_t;

   localparam xgmii_word_t XGMII_IDLE_WORD = '{ctrl: XGMII_IDLE_CTRL, data: XGMII_IDLE_DATA};

endpackage

// File: rtl/xgmii_fifo_ram.sv
// Simple dual-port DEPTH x 72 RAM, one clock, registered read port that resets to XGMII idle.
// Read latency 1 cycle; no backpressure, read port holds its last value while i_rd_en is low.
module xgmii_fifo_ram
   import xgmii_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wr_en,
   input  logic [AW-1:0]     i_wr_addr,
   input  xgmii_word_t       i_wr_dat,
   input  logic              i_rd_en,
   input  logic [AW-1:0]     i_rd_addr,
   output xgmii_word_t       o_rd_dat
);

   xgmii_word_t r_mem [DEPTH];
   xgmii_word_t r_rd_dat;

   // Storage is deliberately not reset so it maps onto plain RAM.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_dat;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_dat <= XGMII_IDLE_WORD;
      end else if (i_rd_en) begin
         r_rd_dat <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/xgmii_fifo.sv
// Fixed-latency XGMII elastic buffer: emits idle until FILL words are buffered, then input delayed by FILL
// cycles (FILL+1 when XGMII_FIFO_OUTREG_EN is defined). No backpressure: one word in and out every clock.
module xgmii_fifo
   import xgmii_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int FILL  = 8
) (
   input  logic                wr_clk,
   input  logic                wr_rst,
   input  logic [XGMII_DW-1:0] wr_data,
   input  logic [XGMII_CW-1:0] wr_ctrl,
   output logic [XGMII_DW-1:0] rd_data,
   output logic [XGMII_CW-1:0] rd_ctrl
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(FILL + 1);

   generate
      if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("xgmii_fifo: DEPTH must be a power of two and at least 4");
      end
      if (FILL < 1 || FILL > DEPTH - 1) begin : g_bad_fill
         $error("xgmii_fifo: FILL must lie in 1..DEPTH-1");
      end
   endgenerate

   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [LW-1:0] r_lvl;
   logic          r_primed;

   xgmii_word_t   w_wr_word;
   xgmii_word_t   w_ram_q;
   xgmii_word_t   w_out;

   assign w_wr_word = '{ctrl: wr_ctrl, data: wr_data};

   // Read pointer only moves once primed, so it trails the write pointer by exactly FILL.
   always_ff @(posedge wr_clk or negedge wr_rst) begin
      if (!wr_rst) begin
         r_wp     <= '0;
         r_rp     <= '0;
         r_lvl    <= '0;
         r_primed <= 1'b0;
      end else begin
         r_wp <= r_wp + AW'(1);
         if (r_primed) begin
            r_rp <= r_rp + AW'(1);
         end
         if (r_lvl != LW'(FILL)) begin
            r_lvl    <= r_lvl + LW'(1);
            r_primed <= (r_lvl == LW'(FILL - 1));
         end
      end
   end

   xgmii_fifo_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .i_clk     (wr_clk),
      .i_rst_n   (wr_rst),
      .i_wr_en   (1'b1),
      .i_wr_addr (r_wp),
      .i_wr_dat  (w_wr_word),
      .i_rd_en   (r_primed),
      .i_rd_addr (r_rp),
      .o_rd_dat  (w_ram_q)
   );

`ifdef XGMII_FIFO_OUTREG_EN
   xgmii_word_t r_out;

   always_ff @(posedge wr_clk or negedge wr_rst) begin
      if (!wr_rst) begin
         r_out <= XGMII_IDLE_WORD;
      end else begin
         r_out <= w_ram_q;
      end
   end

   assign w_out = r_out;
`else
   assign w_out = w_ram_q;
`endif

   assign rd_data = w_out.data;
   assign rd_ctrl = w_out.ctrl;

endmodule

// File: tb/tb_xgmii_fifo.sv
// Directed bench for xgmii_fifo: idle fill, single/sequence control words, wrap streaming, mid-stream reset.
// Expected output is the input history delayed by LAT edges since reset release, idle before that.
module tb_xgmii_fifo;

   localparam int DEPTH = 16;
   localparam int FILL  = 8;
`ifdef XGMII_FIFO_OUTREG_EN
   localparam int LAT = FILL + 1;
`else
   localparam int LAT = FILL;
`endif
   localparam logic [63:0] IDLE_D = 64'h0707070707070707;
   localparam logic [71:0] IDLE   = {8'hFF, 64'h0707070707070707};

   logic        wr_clk = 1'b0;
   logic        wr_rst;
   logic [63:0] wr_data;
   logic [7:0]  wr_ctrl;
   logic [63:0] rd_data;
   logic [7:0]  rd_ctrl;

   int          checks = 0;
   int          errors = 0;
   int          k      = 0;
   logic [71:0] hist [0:511];

   always #5 wr_clk = ~wr_clk;

   xgmii_fifo #(
      .DEPTH (DEPTH),
      .FILL  (FILL)
   ) dut (
      .wr_clk  (wr_clk),
      .wr_rst  (wr_rst),
      .wr_data (wr_data),
      .wr_ctrl (wr_ctrl),
      .rd_data (rd_data),
      .rd_ctrl (rd_ctrl)
   );

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [71:0] exp_word(input int kk);
      return (kk <= LAT) ? IDLE : hist[kk - LAT];
   endfunction

   // Called at a falling edge: drive, take one rising edge, check at the next falling edge.
   task automatic cyc(input logic [63:0] d, input logic [7:0] c, input string tag);
      wr_data = d;
      wr_ctrl = c;
      @(posedge wr_clk);
      k++;
      hist[k] = {c, d};
      @(negedge wr_clk);
      check(tag, {rd_ctrl, rd_data}, exp_word(k));
   endtask

   int s;
   int found;

   initial begin
      wr_rst  = 1'b0;
      wr_data = 64'hDEADBEEF00000001;
      wr_ctrl = 8'h00;
      repeat (3) begin
         @(negedge wr_clk);
         check("reset", {rd_ctrl, rd_data}, IDLE);
      end
      wr_rst = 1'b1;
      k      = 0;

      for (int i = 0; i < 40; i++) begin
         cyc(IDLE_D, 8'hFF, "idle");
         check("idle_abs", {rd_ctrl, rd_data}, IDLE);
      end

      s     = k + 1;
      found = -1;
      cyc(IDLE_D, 8'h01, "ctl01");
      for (int i = 0; i < 14; i++) begin
         cyc(IDLE_D, 8'hFF, "ctl01_tail");
         if (rd_ctrl == 8'h01 && found < 0) found = k;
      end
      check("lat01", 72'(found - s), 72'(LAT));

      for (int i = 0; i < 6; i++) begin
         cyc(64'h123456789abcdef0, 8'(i + 2), "seq");
      end
      cyc(64'h123456789abcdef0, 8'hFF, "seq");
      for (int i = 0; i < 10; i++) begin
         cyc(IDLE_D, 8'hFF, "seq_tail");
      end

      for (int i = 0; i < 3 * DEPTH; i++) begin
         cyc({16'hC0DE, 16'(i), 32'(i)}, 8'(i), "wrap");
      end

      // Output is mid-stream (non-idle) here; reset must clear it without a clock edge.
      wr_data = 64'h5555AAAA5555AAAA;
      wr_ctrl = 8'h3C;
      @(posedge wr_clk);
      #2 wr_rst = 1'b0;
      #1 check("async_rst", {rd_ctrl, rd_data}, IDLE);
      @(negedge wr_clk);
      check("rst_hold", {rd_ctrl, rd_data}, IDLE);
      @(negedge wr_clk);
      check("rst_hold", {rd_ctrl, rd_data}, IDLE);
      wr_rst = 1'b1;
      k      = 0;

      for (int i = 0; i < 20; i++) begin
         cyc({16'hBEEF, 16'(i), 32'hFFFF0000 | 32'(i)}, 8'hA0 ^ 8'(i), "post_rst");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
